// File: rtl/forwarding_pkg.sv
// Shared definitions for the EX-side forwarding and load-use hazard unit.
// Shadow entry layout, MSB first: {valid, we, is_load, dest}.
package forwarding_pkg;

  localparam int FWD_REGFILE = 0;
  localparam int ENT_FLAGS   = 3;

  typedef struct packed {
    logic valid;
    logic we;
    logic is_load;
  } ent_flags_t;

  function automatic int ent_w(input int aw);
    return aw + ENT_FLAGS;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fwd_prio_match.sv
// Nearest-stage match for one EX source operand.
// Returns the forward select and whether the nearest producer is an unready load.
module fwd_prio_match
  import forwarding_pkg::*;
#(
  parameter int AW       = 3,
  parameter int STAGES   = 2,
  parameter int LD_READY = 2,
  parameter bit ZERO_REG = 1'b0,
  parameter int SEL_W    = 2
) (
  input  logic                         en,
  input  logic [AW-1:0]                addr,
  input  logic [STAGES*ent_w(AW)-1:0]  entries,
  output logic [SEL_W-1:0]             sel,
  output logic                         hazard
);

  localparam int EW = ent_w(AW);

  logic [EW-1:0] e;
  ent_flags_t    f;
  logic          zero_blk;

  // Scan farthest to nearest so the nearest match is the last write.
  always_comb begin
    sel      = SEL_W'(FWD_REGFILE);
    hazard   = 1'b0;
    e        = '0;
    f        = '0;
    zero_blk = ZERO_REG && (addr == '0);
    for (int s = STAGES; s >= 1; s--) begin
      e = entries[(s-1)*EW +: EW];
      f = e[EW-1 -: ENT_FLAGS];
      if (en && f.valid && f.we && !zero_blk &&
          e[AW-1:0] == addr) begin
        hazard = f.is_load && (s < LD_READY);
        sel    = hazard ? SEL_W'(FWD_REGFILE)
                        : SEL_W'(s);
      end
    end
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Shadow destination pipe after EX, per-source forward selects,
// load-use stall generation and a saturating stall-cycle counter.
module forwarding_hazard_unit
  import forwarding_pkg::*;
#(
  parameter int  REG_ADDR_W = 3,
  parameter int  STAGES     = 2,
  parameter int  NUM_SRC    = 3,
  parameter int  LD_READY   = 2,
  parameter bit  ZERO_REG   = 1'b0,
  parameter int  CNT_W      = 16,
  localparam int SEL_W      = clog2(STAGES + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pipe_hold,
  input  logic                          ex_valid,
  input  logic                          ex_reg_write,
  input  logic                          ex_is_load,
  input  logic [REG_ADDR_W-1:0]         ex_dest,
  input  logic [NUM_SRC-1:0]            src_en,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic                          stall,
  output logic [CNT_W-1:0]              stall_count
);

  localparam int EW = ent_w(REG_ADDR_W);

  if (LD_READY < 1 || LD_READY > STAGES) begin : g_bad_ld_ready
    $error("LD_READY must lie in 1..STAGES");
  end

  logic [STAGES*EW-1:0] shadow;
  logic [EW-1:0]        ex_ent;
  logic [NUM_SRC-1:0]   hazard;

  // A stall turns the instruction leaving EX into a bubble.
  assign ex_ent = stall ? '0
                : {ex_valid, ex_reg_write, ex_is_load, ex_dest};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow      <= '0;
      stall_count <= '0;
    end else if (!pipe_hold) begin
      shadow[EW-1:0] <= ex_ent;
      for (int s = 1; s < STAGES; s++)
        shadow[s*EW +: EW] <= shadow[(s-1)*EW +: EW];
      if (stall && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_prio_match #(
      .AW       (REG_ADDR_W),
      .STAGES   (STAGES),
      .LD_READY (LD_READY),
      .ZERO_REG (ZERO_REG),
      .SEL_W    (SEL_W)
    ) u_match (
      .en      (src_en[g]),
      .addr    (src_addr[g*REG_ADDR_W +: REG_ADDR_W]),
      .entries (shadow),
      .sel     (fwd_sel[g*SEL_W +: SEL_W]),
      .hazard  (hazard[g])
    );
  end

  assign stall = |hazard;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Bench for forwarding_hazard_unit: default instance plus a
// ZERO_REG=1 / CNT_W=2 instance, both checked against a pipeline model.
module tb_forwarding_hazard_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pipe_hold = 1'b0;
  logic       ex_valid = 1'b0;
  logic       ex_reg_write = 1'b0;
  logic       ex_is_load = 1'b0;
  logic [2:0] ex_dest = '0;
  logic [2:0] src_en = '0;
  logic [8:0] src_addr = '0;

  logic [5:0]  sel0, sel1;
  logic        st0, st1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  always #5 clk = ~clk;

  forwarding_hazard_unit u_dut0 (
    .clk(clk), .reset(reset), .pipe_hold(pipe_hold),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_is_load(ex_is_load), .ex_dest(ex_dest),
    .src_en(src_en), .src_addr(src_addr),
    .fwd_sel(sel0), .stall(st0), .stall_count(cnt0)
  );

  forwarding_hazard_unit #(.ZERO_REG(1'b1), .CNT_W(2)) u_dut1 (
    .clk(clk), .reset(reset), .pipe_hold(pipe_hold),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_is_load(ex_is_load), .ex_dest(ex_dest),
    .src_en(src_en), .src_addr(src_addr),
    .fwd_sel(sel1), .stall(st1), .stall_count(cnt1)
  );

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model: sh[k][1] is MEM, sh[k][2] is WB; load data usable from WB.
  typedef struct packed {
    bit       v;
    bit       we;
    bit       ld;
    bit [2:0] d;
  } ment_t;

  ment_t sh [2][1:2];
  int    mcnt [2];
  int    cmax [2] = '{65535, 3};

  function automatic int m_sel(input int k, input int i, output bit hz);
    bit [2:0] a;
    a  = src_addr[i*3 +: 3];
    hz = 1'b0;
    if (!src_en[i] || (k == 1 && a == 3'd0)) return 0;
    for (int s = 1; s <= 2; s++) begin
      if (sh[k][s].v && sh[k][s].we && sh[k][s].d == a) begin
        if (sh[k][s].ld && s < 2) begin
          hz = 1'b1;
          return 0;
        end
        return s;
      end
    end
    return 0;
  endfunction

  function automatic bit m_stall(input int k);
    bit hz;
    bit any;
    any = 1'b0;
    for (int i = 0; i < 3; i++) begin
      void'(m_sel(k, i, hz));
      any |= hz;
    end
    return any;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      sh[k][1] = '0;
      sh[k][2] = '0;
      mcnt[k]  = 0;
    end
  endtask

  task automatic check_all();
    bit hz;
    int e;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        e = m_sel(k, i, hz);
        chk($sformatf("sel_d%0d_s%0d", k, i),
            k == 0 ? sel0[i*2 +: 2] : sel1[i*2 +: 2], e);
      end
      chk($sformatf("stall_d%0d", k), k == 0 ? st0 : st1,
          m_stall(k));
      chk($sformatf("count_d%0d", k),
          k == 0 ? 32'(cnt0) : 32'(cnt1), mcnt[k]);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_all();
  endtask

  task automatic adv();
    bit s [2];
    @(posedge clk);
    for (int k = 0; k < 2; k++) s[k] = m_stall(k);
    for (int k = 0; k < 2; k++) begin
      if (!pipe_hold) begin
        sh[k][2] = sh[k][1];
        sh[k][1] = s[k] ? '0
          : '{v: ex_valid, we: ex_reg_write,
              ld: ex_is_load, d: ex_dest};
        if (s[k] && mcnt[k] < cmax[k]) mcnt[k]++;
      end
    end
    #1;
  endtask

  task automatic set_ex(input bit v, input bit we,
                        input bit ld, input bit [2:0] d);
    ex_valid     = v;
    ex_reg_write = we;
    ex_is_load   = ld;
    ex_dest      = d;
  endtask

  task automatic set_src(input int i, input bit en, input bit [2:0] a);
    src_en[i]          = en;
    src_addr[i*3 +: 3] = a;
  endtask

  task automatic clr();
    set_ex(0, 0, 0, 0);
    src_en   = '0;
    src_addr = '0;
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_stall0", st0, 0);
    chk("rst_sel0", sel0, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    @(negedge clk);
    reset = 1'b1;
    adv();

    // ALU write r3, then read from MEM and from WB
    set_ex(1, 1, 0, 3);
    sample(); adv();
    set_ex(0, 0, 0, 0);
    set_src(0, 1, 3);
    sample();
    chk("alu_mem_sel0", sel0[1:0], 1);
    adv();
    set_src(0, 0, 0);
    set_src(1, 1, 3);
    sample();
    chk("alu_wb_sel1", sel0[3:2], 2);
    chk("alu_wb_stall", st0, 0);
    adv();
    clr();

    // r5 in both stages: nearest wins
    set_ex(1, 1, 0, 5); adv();
    set_ex(1, 1, 0, 5); adv();
    set_ex(0, 0, 0, 0);
    set_src(2, 1, 5);
    sample();
    chk("near_sel2", sel0[5:4], 1);
    set_src(2, 0, 5);
    #1;
    chk("near_en0_sel2", sel0[5:4], 0);
    adv();
    clr();
    set_ex(1, 1, 0, 5); adv();
    set_ex(1, 0, 0, 5); adv();
    set_ex(0, 0, 0, 0);
    set_src(2, 1, 5);
    sample();
    chk("near_we0_sel2", sel0[5:4], 2);
    adv();
    clr();

    // load-use: one stall, then forward from WB
    set_ex(1, 1, 1, 2); adv();
    set_ex(0, 0, 0, 0);
    set_src(0, 1, 2);
    sample();
    chk("lu_stall", st0, 1);
    chk("lu_sel0", sel0[1:0], 0);
    adv();
    sample();
    chk("lu_after_stall", st0, 0);
    chk("lu_after_sel0", sel0[1:0], 2);
    chk("lu_after_cnt", cnt0, 1);
    adv();
    clr();

    // load-use under pipe_hold
    set_ex(1, 1, 1, 2); adv();
    set_ex(0, 0, 0, 0);
    set_src(0, 1, 2);
    pipe_hold = 1'b1;
    repeat (3) begin
      sample();
      chk("hold_stall", st0, 1);
      chk("hold_cnt", cnt0, 1);
      adv();
    end
    pipe_hold = 1'b0;
    sample();
    chk("rel_stall", st0, 1);
    adv();
    sample();
    chk("rel_done_stall", st0, 0);
    chk("rel_done_cnt", cnt0, 2);
    chk("rel_done_sel0", sel0[1:0], 2);
    adv();
    clr();

    // r0 forwarding with and without ZERO_REG
    set_ex(1, 1, 0, 0); adv();
    set_ex(0, 0, 0, 0);
    set_src(0, 1, 0);
    sample();
    chk("r0_sel_zr0", sel0[1:0], 1);
    chk("r0_sel_zr1", sel1[1:0], 0);
    chk("r0_stall_zr1", st1, 0);
    adv();
    clr();

    // async reset in the middle of a stall
    set_ex(1, 1, 1, 2); adv();
    set_ex(0, 0, 0, 0);
    set_src(0, 1, 2);
    sample();
    chk("mid_stall", st0, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_stall0", st0, 0);
    chk("arst_stall1", st1, 0);
    chk("arst_sel0", sel0, 0);
    chk("arst_sel1", sel1, 0);
    chk("arst_cnt0", cnt0, 0);
    chk("arst_cnt1", cnt1, 0);
    model_reset();
    #1 reset = 1'b1;
    adv();
    clr();

    // counter saturation on the 2-bit instance
    repeat (5) begin
      set_ex(1, 1, 1, 2);
      src_en = '0;
      adv();
      set_ex(0, 0, 0, 0);
      set_src(0, 1, 2);
      sample();
      adv();
    end
    clr();
    sample();
    chk("sat_cnt1", cnt1, 3);
    chk("sat_cnt0", cnt0, 5);
    adv();

    // randomized traffic against the model
    repeat (400) begin
      pipe_hold    = ($urandom_range(0, 4) == 0);
      ex_valid     = ($urandom_range(0, 4) != 0);
      ex_reg_write = $urandom_range(0, 1);
      ex_is_load   = $urandom_range(0, 1);
      ex_dest      = 3'($urandom_range(0, 3));
      src_en       = 3'($urandom);
      for (int i = 0; i < 3; i++)
        src_addr[i*3 +: 3] = 3'($urandom_range(0, 3));
      sample();
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 reset = 1'b1;
      end
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
